progmem_arbiter: RTL and testbench

- Two-master read arbiter that shares one program-memory slave port (Avalon-style read/waitrequest/response, 32-bit data) between two requesters, e.g. a sequencer's instruction fetch and a debug/config reader.
- Round-robin grant with grant held until transfer completion.
- A watchdog terminates transfers the slave never completes and returns an error response.

---
 rtl/progmem_arbiter_if.sv | 14 +
 rtl/progmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_progmem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/progmem_arbiter_if.sv
// Avalon-style read port bundle shared by the two masters and the program-memory slave.
// The arbiter takes the slave modport toward each master and the master modport toward memory.
interface progmem_arbiter_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic [ADDR_W-1:0] address;
  logic              read;
  logic [31:0]       readdata;
  logic [1:0]        response;
  logic              waitrequest;

  modport master (output address, read, input readdata, response, waitrequest);
  modport slave  (input address, read, output readdata, response, waitrequest);
endinterface

// File: rtl/progmem_arbiter.sv
// Two-master round-robin read arbiter in front of one program-memory port, with a
// stall watchdog that forces an SLVERR completion when the slave never answers.
module progmem_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  progmem_arbiter_if.slave    m0,
  progmem_arbiter_if.slave    m1,
  progmem_arbiter_if.master   s,
  output logic                busy,
  output logic [ERRCNT_W-1:0] timeout_count
);

  localparam int unsigned     WD_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned     WD_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(WD_LAST_I);
  localparam logic [1:0]      RESP_OK     = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_TERM} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [ERRCNT_W-1:0]   tcnt_q, tcnt_d;

  logic                  own_read;
  logic [ADDR_W-1:0]     own_addr;

  assign own_read      = owner_q ? m1.read    : m0.read;
  assign own_addr      = owner_q ? m1.address : m0.address;
  assign timeout_count = tcnt_q;

  // State and bookkeeping registers; last_q=1 lets master 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wd_q    <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Next-state: registered grant in IDLE, completion/abandon/watchdog in BUSY.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wd_d    = wd_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (m0.read && m1.read) begin
          owner_d = ~last_q;
          state_d = ST_BUSY;
        end else if (m0.read) begin
          owner_d = 1'b0;
          state_d = ST_BUSY;
        end else if (m1.read) begin
          owner_d = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!own_read || !s.waitrequest) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
          wd_d    = '0;
        end else if (TIMEOUT != 0) begin
          if (wd_q == WD_LAST) begin
            state_d = ST_TERM;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
      end
      ST_TERM: begin
        state_d = ST_IDLE;
        last_d  = owner_q;
        wd_d    = '0;
        if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + ERRCNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: owner sees the slave in BUSY, a forced SLVERR in TERM; everyone else stalls.
  always_comb begin
    busy           = 1'b0;
    s.read         = 1'b0;
    s.address      = '0;
    m0.waitrequest = 1'b1;
    m0.readdata    = '0;
    m0.response    = RESP_OK;
    m1.waitrequest = 1'b1;
    m1.readdata    = '0;
    m1.response    = RESP_OK;
    unique case (state_q)
      ST_BUSY: begin
        busy      = 1'b1;
        s.read    = own_read;
        s.address = own_addr;
        if (owner_q) begin
          m1.waitrequest = s.waitrequest;
          m1.readdata    = s.readdata;
          m1.response    = s.response;
        end else begin
          m0.waitrequest = s.waitrequest;
          m0.readdata    = s.readdata;
          m0.response    = s.response;
        end
      end
      ST_TERM: begin
        busy = 1'b1;
        if (owner_q) begin
          m1.waitrequest = 1'b0;
          m1.response    = RESP_SLVERR;
        end else begin
          m0.waitrequest = 1'b0;
          m0.response    = RESP_SLVERR;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_progmem_arbiter.sv
// Scoreboard bench for progmem_arbiter: watchdog instance (TIMEOUT=64) plus a
// watchdog-disabled instance used for the long-stall case.
module tb_progmem_arbiter;
  localparam int unsigned ADDR_W = 12;

  typedef struct packed {
    logic        mst;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy, busy2;
  logic [7:0] tcnt, tcnt2;

  always #5 clk = ~clk;

  progmem_arbiter_if #(.ADDR_W(ADDR_W)) m0_if ();
  progmem_arbiter_if #(.ADDR_W(ADDR_W)) m1_if ();
  progmem_arbiter_if #(.ADDR_W(ADDR_W)) s_if ();
  progmem_arbiter_if #(.ADDR_W(ADDR_W)) n0_if ();
  progmem_arbiter_if #(.ADDR_W(ADDR_W)) n1_if ();
  progmem_arbiter_if #(.ADDR_W(ADDR_W)) t_if ();

  progmem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(64), .ERRCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if), .s(s_if),
    .busy(busy), .timeout_count(tcnt)
  );

  progmem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(0), .ERRCNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .m0(n0_if), .m1(n1_if), .s(t_if),
    .busy(busy2), .timeout_count(tcnt2)
  );

  function automatic logic [31:0] slv_data(input logic [11:0] a);
    return 32'hDEADBEEF ^ {20'h0, a ^ 12'h010};
  endfunction

  // Slave model: ws wait states per read, or stall forever; address 0xBAD answers SLVERR.
  int ws = 1;
  bit stall_forever = 1'b0;
  int scnt = 0;
  int scnt2 = 0;

  always @(posedge clk) begin
    if (!s_if.read || !s_if.waitrequest) scnt <= 0;
    else scnt <= scnt + 1;
    if (!t_if.read || !t_if.waitrequest) scnt2 <= 0;
    else scnt2 <= scnt2 + 1;
  end

  assign s_if.waitrequest = stall_forever || !(s_if.read && scnt >= ws);
  assign s_if.readdata    = s_if.read ? slv_data(s_if.address) : 32'h0;
  assign s_if.response    = (s_if.read && s_if.address == 12'hBAD) ? 2'b10 : 2'b00;
  assign t_if.waitrequest = !(t_if.read && scnt2 >= 1000);
  assign t_if.readdata    = t_if.read ? slv_data(t_if.address) : 32'h0;
  assign t_if.response    = 2'b00;

  exp_t           sb[$];
  logic [11:0]    mq0[$];
  logic [11:0]    mq1[$];
  int             checks = 0;
  int             failures = 0;

  task automatic set_m(input int k, input logic rd, input logic [11:0] a);
    if (k == 0) begin m0_if.read = rd; m0_if.address = a; end
    else        begin m1_if.read = rd; m1_if.address = a; end
  endtask

  // Drives both masters from their queues, re-requesting immediately after each completion.
  task automatic run(input int budget);
    logic        rd[2], wr[2];
    logic [31:0] rdat[2];
    logic [1:0]  rsp[2];
    exp_t        e, got;
    bit          finished = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      rd[0] = m0_if.read; wr[0] = m0_if.waitrequest; rdat[0] = m0_if.readdata; rsp[0] = m0_if.response;
      rd[1] = m1_if.read; wr[1] = m1_if.waitrequest; rdat[1] = m1_if.readdata; rsp[1] = m1_if.response;
      for (int k = 0; k < 2; k++) begin
        if (rd[k] && !wr[k]) begin
          checks++;
          got.mst = 1'(k); got.data = rdat[k]; got.resp = rsp[k];
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL run_unexpected got m%0d data=%h resp=%b, required no completion", k, rdat[k], rsp[k]);
          end else begin
            e = sb.pop_front();
            if (got !== e)  begin
              failures++;
              $display("FAIL run_completion got m%0d data=%h resp=%b, required m%0d data=%h resp=%b",
                       got.mst, got.data, got.resp, e.mst, e.data, e.resp);
            end
          end
        end
        if (!rd[k] || !wr[k]) begin
          if (k == 0 && mq0.size() > 0)      set_m(0, 1'b1, mq0.pop_front());
          else if (k == 1 && mq1.size() > 0) set_m(1, 1'b1, mq1.pop_front());
          else                               set_m(k, 1'b0, 12'h0);
        end
      end
      if (mq0.size() == 0 && mq1.size() == 0 && !m0_if.read && !m1_if.read) begin
        finished = 1'b1;
        break;
      end
    end
    checks++;
    if (!finished || sb.size() != 0) begin
      failures++;
      $display("FAIL run_drain finished=%0d left=%0d, required finished=1 left=0", finished, sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({s_if.read, s_if.address, busy, m0_if.waitrequest, m1_if.waitrequest} !== {1'b0, 12'h0, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL reset_ctrl got s_read=%b s_addr=%h busy=%b wr0=%b wr1=%b, required 0 000 0 1 1",
               s_if.read, s_if.address, busy, m0_if.waitrequest, m1_if.waitrequest);
    end
    checks++;
    if ({m0_if.readdata, m1_if.readdata, m0_if.response, m1_if.response, tcnt} !== 76'h0) begin
      failures++;
      $display("FAIL reset_data got rd0=%h rd1=%h rs0=%b rs1=%b tcnt=%0d, required all zero",
               m0_if.readdata, m1_if.readdata, m0_if.response, m1_if.response, tcnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alternate();
    mq0 = '{12'h004, 12'h00C};
    mq1 = '{12'h008, 12'hBAD};
    sb.push_back('{1'b0, slv_data(12'h004), 2'b00});
    sb.push_back('{1'b1, slv_data(12'h008), 2'b00});
    sb.push_back('{1'b0, slv_data(12'h00C), 2'b00});
    sb.push_back('{1'b1, slv_data(12'hBAD), 2'b10});
    run(200);
  endtask

  task automatic test_single();
    exp_t e;
    @(negedge clk);
    set_m(0, 1'b1, 12'h010);
    sb.push_back('{1'b0, 32'hDEADBEEF, 2'b00});
    #1;
    checks++;
    if ({s_if.read, m0_if.waitrequest} !== 2'b01) begin
      failures++;
      $display("FAIL single_req_cycle got s_read=%b wr0=%b, required 0 1", s_if.read, m0_if.waitrequest);
    end
    @(negedge clk);
    checks++;
    if ({s_if.read, s_if.address, m0_if.waitrequest, busy} !== {1'b1, 12'h010, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL single_grant got s_read=%b s_addr=%h wr0=%b busy=%b, required 1 010 1 1",
               s_if.read, s_if.address, m0_if.waitrequest, busy);
    end
    @(negedge clk);
    checks++;
    e = sb.pop_front();
    if ({m0_if.waitrequest, m0_if.readdata, m0_if.response} !== {1'b0, e.data, e.resp}) begin
      failures++;
      $display("FAIL single_done got wr0=%b data=%h resp=%b, required 0 %h %b",
               m0_if.waitrequest, m0_if.readdata, m0_if.response, e.data, e.resp);
    end
    checks++;
    if ({m1_if.waitrequest, m1_if.readdata} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL single_nonowner got wr1=%b rd1=%h, required 1 00000000", m1_if.waitrequest, m1_if.readdata);
    end
    set_m(0, 1'b0, 12'h0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int   n = 0;
    bit   seen = 1'b0;
    stall_forever = 1'b1;
    @(negedge clk);
    set_m(1, 1'b1, 12'h020);
    sb.push_back('{1'b1, 32'h0, 2'b10});
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!m1_if.waitrequest) begin seen = 1'b1; break; end
      if (busy && s_if.read) n++;
    end
    checks++;
    if (!seen || n != 64) begin
      failures++;
      $display("FAIL timeout_len got seen=%0d stall_cycles=%0d, required 1 64", seen, n);
    end
    checks++;
    e = sb.pop_front();
    if ({m1_if.readdata, m1_if.response, s_if.read, busy} !== {e.data, e.resp, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL timeout_term got data=%h resp=%b s_read=%b busy=%b, required %h %b 0 1",
               m1_if.readdata, m1_if.response, s_if.read, busy, e.data, e.resp);
    end
    set_m(1, 1'b0, 12'h0);
    @(negedge clk);
    checks++;
    if ({tcnt, busy} !== {8'd1, 1'b0}) begin
      failures++;
      $display("FAIL timeout_count got tcnt=%0d busy=%b, required 1 0", tcnt, busy);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 299; i++) begin
      mq1.push_back(12'(12'h100 + i));
      sb.push_back('{1'b1, 32'h0, 2'b10});
    end
    run(30000);
    checks++;
    if (tcnt !== 8'd255) begin
      failures++;
      $display("FAIL saturate got tcnt=%0d, required 255", tcnt);
    end
    stall_forever = 1'b0;
  endtask

  task automatic test_no_timeout();
    exp_t e;
    int   n = 0;
    bit   seen = 1'b0;
    @(negedge clk);
    n0_if.read = 1'b1; n0_if.address = 12'h030;
    sb.push_back('{1'b0, slv_data(12'h030), 2'b00});
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (!n0_if.waitrequest) begin seen = 1'b1; break; end
      if (busy2 && t_if.read) n++;
    end
    checks++;
    e = sb.pop_front();
    if (!seen || n != 1000 || {n0_if.readdata, n0_if.response} !== {e.data, e.resp}) begin
      failures++;
      $display("FAIL no_timeout got seen=%0d stall=%0d data=%h resp=%b, required 1 1000 %h %b",
               seen, n, n0_if.readdata, n0_if.response, e.data, e.resp);
    end
    n0_if.read = 1'b0;
    @(negedge clk);
    checks++;
    if ({tcnt2, busy2} !== {8'd0, 1'b0}) begin
      failures++;
      $display("FAIL no_timeout_count got tcnt=%0d busy=%b, required 0 0", tcnt2, busy2);
    end
  endtask

  task automatic test_reset_mid();
    ws = 10;
    @(negedge clk);
    set_m(0, 1'b1, 12'h040);
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, s_if.read} !== 2'b11) begin
      failures++;
      $display("FAIL rstmid_busy got busy=%b s_read=%b, required 1 1", busy, s_if.read);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_if.read, busy, m0_if.waitrequest, m0_if.readdata, tcnt} !== {1'b0, 1'b0, 1'b1, 32'h0, 8'd0}) begin
      failures++;
      $display("FAIL rstmid_async got s_read=%b busy=%b wr0=%b rd0=%h tcnt=%0d, required 0 0 1 00000000 0",
               s_if.read, busy, m0_if.waitrequest, m0_if.readdata, tcnt);
    end
    set_m(0, 1'b0, 12'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ws = 1;
    mq1.push_back(12'h044);
    sb.push_back('{1'b1, slv_data(12'h044), 2'b00});
    run(50);
  endtask

  task automatic test_drop();
    exp_t e;
    bit   seen = 1'b0;
    stall_forever = 1'b1;
    @(negedge clk);
    set_m(0, 1'b1, 12'h050);
    set_m(1, 1'b1, 12'h054);
    sb.push_back('{1'b1, slv_data(12'h054), 2'b00});
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, s_if.read, s_if.address} !== {1'b1, 1'b1, 12'h050}) begin
      failures++;
      $display("FAIL drop_owner got busy=%b s_read=%b s_addr=%h, required 1 1 050", busy, s_if.read, s_if.address);
    end
    set_m(0, 1'b0, 12'h0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle got busy=%b, required 0", busy);
    end
    @(negedge clk);
    checks++;
    if ({busy, s_if.read, s_if.address} !== {1'b1, 1'b1, 12'h054}) begin
      failures++;
      $display("FAIL drop_regrant got busy=%b s_read=%b s_addr=%h, required 1 1 054", busy, s_if.read, s_if.address);
    end
    stall_forever = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!m1_if.waitrequest) begin seen = 1'b1; break; end
    end
    checks++;
    e = sb.pop_front();
    if (!seen || {m1_if.readdata, m1_if.response} !== {e.data, e.resp}) begin
      failures++;
      $display("FAIL drop_m1_done got seen=%0d data=%h resp=%b, required 1 %h %b",
               seen, m1_if.readdata, m1_if.response, e.data, e.resp);
    end
    set_m(1, 1'b0, 12'h0);
    @(negedge clk);
    checks++;
    if ({tcnt, busy} !== {8'd0, 1'b0}) begin
      failures++;
      $display("FAIL drop_noerr got tcnt=%0d busy=%b, required 0 0", tcnt, busy);
    end
  endtask

  initial begin
    m0_if.read = 1'b0; m0_if.address = '0;
    m1_if.read = 1'b0; m1_if.address = '0;
    n0_if.read = 1'b0; n0_if.address = '0;
    n1_if.read = 1'b0; n1_if.address = '0;
    test_reset();
    test_alternate();
    test_single();
    test_timeout();
    test_saturate();
    test_no_timeout();
    test_reset_mid();
    test_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
